// File: rtl/sd_dac_pkg.sv
// sd_dac_pkg: shared widths, types and residue saturation for the sigma-delta DAC
package sd_dac_pkg;
  localparam int W_DEF = 4;
  localparam int RW_DEF = 4;
  typedef logic [W_DEF-1:0] code_t;
  typedef logic signed [2:0] mash_t;
  function automatic logic signed [7:0] sat_res(input logic signed [7:0] v, input int rw);
    int hi;
    int lo;
    hi = (1 << (rw - 1)) - 1;
    lo = -hi - 1;
    return (int'(v) > hi) ? 8'(hi) : (int'(v) < lo) ? 8'(lo) : v;
  endfunction
endpackage

// File: rtl/sd_accum_stage.sv
// sd_accum_stage: W-bit wrapping accumulator (clk, rst, din in; acc state and registered carry out)
module sd_accum_stage
  import sd_dac_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] acc,
  output logic         carry
);
  logic [W-1:0] acc_q, acc_d;
  logic carry_q, carry_d;
  always_comb {carry_d, acc_d} = {1'b0, acc_q} + {1'b0, din};
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      carry_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      carry_q <= carry_d;
    end
  end
  assign acc = acc_q;
  assign carry = carry_q;
endmodule

// File: rtl/sigma_delta_dac.sv
// sigma_delta_dac: MASH 1-1 modulator plus 1-bit requantizer (clk, rst, x1 code in; y registered bitstream out)
module sigma_delta_dac
  import sd_dac_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int RW = RW_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] x1,
  output logic         y
);
  logic [W-1:0] acc1, acc2;
  logic c1_q, c2_q;
  logic c2_dly_q, c2_dly_d;
  logic signed [RW-1:0] r_q, r_d;
  logic y_q, y_d;
  mash_t q;
  logic signed [7:0] t;
  sd_accum_stage #(.W(W)) u_s1 (.clk(clk), .rst(rst), .din(x1), .acc(acc1), .carry(c1_q));
  sd_accum_stage #(.W(W)) u_s2 (.clk(clk), .rst(rst), .din(acc1), .acc(acc2), .carry(c2_q));
  always_comb begin
    c2_dly_d = c2_q;
    q = mash_t'({2'b0, c1_q}) + mash_t'({2'b0, c2_q}) - mash_t'({2'b0, c2_dly_q});
    t = 8'(r_q) + 8'(q);
    y_d = t > 8'sd0;
    r_d = RW'(sat_res(y_d ? t - 8'sd1 : t, RW));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      c2_dly_q <= 1'b0;
      r_q <= '0;
      y_q <= 1'b0;
    end else begin
      c2_dly_q <= c2_dly_d;
      r_q <= r_d;
      y_q <= y_d;
    end
  end
  assign y = y_q;
endmodule

// File: tb/tb_sigma_delta_dac.sv
// tb_sigma_delta_dac: randomized scoreboard bench for sigma_delta_dac against an arithmetic model
module tb_sigma_delta_dac;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] x1 = 4'd0;
  logic y;
  int total = 0;
  int bad = 0;
  bit ysamp;
  bit exp_q[$];
  bit first_run[37];
  int m_a1 = 0, m_a2 = 0, m_c1 = 0, m_c2 = 0, m_c2d = 0, m_r = 0;
  bit m_y = 1'b0;
  sigma_delta_dac dut (.clk(clk), .rst(rst), .x1(x1), .y(y));
  always #5 clk = ~clk;
  function automatic void chk(input string nm, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d want %0d..%0d at %0t", nm, act, lo, hi, $time);
    end
  endfunction
  always @(posedge clk) begin
    int s1, s2, t;
    if (rst) begin
      m_a1 = 0; m_a2 = 0; m_c1 = 0; m_c2 = 0; m_c2d = 0; m_r = 0; m_y = 1'b0;
    end else begin
      s1 = m_a1 + int'(x1);
      s2 = m_a2 + m_a1;
      t = m_r + m_c1 + m_c2 - m_c2d;
      m_c2d = m_c2;
      m_a1 = s1 % 16;
      m_c1 = s1 / 16;
      m_a2 = s2 % 16;
      m_c2 = s2 / 16;
      m_y = t >= 1;
      m_r = m_y ? t - 1 : t;
    end
    exp_q.push_back(m_y);
  end
  always @(negedge clk) begin
    bit e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("y_vs_model", int'(y), int'(e), int'(e));
      chk("residue_bound", int'(dut.r_q), -4, 3);
    end
  end
  task automatic step(input bit r, input logic [3:0] x);
    @(negedge clk);
    ysamp = y;
    rst = r;
    x1 = x;
  endtask
  task automatic chk_zero(input string nm);
    chk({nm, "_y"}, int'(y), 0, 0);
    chk({nm, "_acc1"}, int'(dut.acc1), 0, 0);
    chk({nm, "_acc2"}, int'(dut.acc2), 0, 0);
    chk({nm, "_r"}, int'(dut.r_q), 0, 0);
  endtask
  task automatic run_const(input logic [3:0] x, input int n, input int win, input string nm);
    int xi, ones, zeros32, pairs, k;
    bit prev;
    xi = int'(x);
    ones = 0; zeros32 = 0; pairs = 0; prev = 1'b0;
    for (int i = 0; i < n; i++) begin
      step(1'b0, x);
      if (i >= 34) begin
        k = i - 34;
        ones += int'(ysamp);
        pairs += int'(prev & ysamp);
        zeros32 += int'(!ysamp);
        if (k % win == win - 1) begin
          chk({nm, "_density"}, ones, xi * win / 16 - 2, xi * win / 16 + 2);
          if (xi == 1) chk({nm, "_pairs"}, pairs, 0, win / 16);
          ones = 0;
          pairs = 0;
        end
        if (k % 32 == 31) begin
          if (xi == 15) chk({nm, "_zero_in_32"}, zeros32, 1, 32);
          zeros32 = 0;
        end
      end
      prev = ysamp;
    end
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not reach the end, want finish");
    $fatal(1);
  end
  initial begin
    int ones;
    logic [3:0] rx;
    step(1'b1, 4'd5);
    step(1'b1, 4'd5);
    chk_zero("rst_hold1");
    step(1'b0, 4'd5);
    chk_zero("rst_hold2");
    step(1'b0, 4'd5);
    chk("post_rst_acc1", int'(dut.acc1), 5, 5);
    step(1'b1, 4'd0);
    for (int i = 0; i < 200; i++) begin
      step(1'b0, 4'd0);
      chk("zero_input", int'(ysamp), 0, 0);
    end
    step(1'b1, 4'd0);
    step(1'b0, 4'd0);
    step(1'b0, 4'd0);
    run_const(4'd1, 1000, 160, "x1");
    step(1'b1, 4'd0);
    run_const(4'd8, 1000, 160, "x8");
    step(1'b1, 4'd0);
    run_const(4'd15, 1000, 160, "x15");
    for (int j = 0; j < 3; j++) begin
      rx = 4'($urandom_range(2, 14));
      step(1'b1, 4'd0);
      run_const(rx, 400, 160, "xrand");
    end
    step(1'b1, 4'd0);
    for (int i = 0; i < 37; i++) begin
      step(1'b0, 4'd11);
      first_run[i] = ysamp;
    end
    step(1'b1, 4'd11);
    step(1'b0, 4'd11);
    chk_zero("mid_rst");
    for (int i = 1; i < 37; i++) begin
      step(1'b0, 4'd11);
      chk("rerun_repeat", int'(ysamp), int'(first_run[i]), int'(first_run[i]));
    end
    step(1'b1, 4'd0);
    for (int v = 0; v < 16; v++) begin
      ones = 0;
      for (int i = 0; i < 64; i++) begin
        step(1'b0, 4'(v));
        if (i >= 16) ones += int'(ysamp);
      end
      chk("ramp_density", ones, 3 * v - 2, 3 * v + 2);
    end
    for (int i = 0; i < 300; i++) step(1'b0, 4'($urandom_range(0, 15)));
    step(1'b0, 4'd0);
    step(1'b0, 4'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
